slow_tick_ctrl: RTL

Run/stop controller for the free-running slow-clock divider used to pace displays and slow logic on the board.
- Sequences a programmable divide counter and exposes a config handshake for the divisor.
- Generates a single-cycle `tick` enable and a 50%-duty-per-tick toggling `slow_clk`.
- Supports periodic or one-shot operation, so downstream logic uses a clock enable rather than a derived clock.

---
 rtl/slow_tick_pkg.sv | 17 +
 rtl/slow_tick_counter.sv | 36 +++
 rtl/slow_tick_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/slow_tick_pkg.sv
// Shared types and helpers for the slow tick divider controller.
package slow_tick_pkg;

  localparam int DEFAULT_N = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } tick_state_t;

  // A divisor of zero has no meaningful period, so it is treated as 1.
  function automatic logic [63:0] sanitize_div(input logic [63:0] d);
    return (d == 64'd0) ? 64'd1 : d;
  endfunction

endpackage

// File: rtl/slow_tick_counter.sv
// N-bit divide counter, counts 0..div-1 while enabled; clear wins over enable.
// tc flags that the advance happening at this edge lands on div-1.
module slow_tick_counter
  import slow_tick_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] div,
  output logic [N-1:0] cnt,
  output logic         tc
);

  localparam logic [N-1:0] ONE = N'(1);
  localparam logic [N-1:0] TWO = N'(2);

  logic at_end;

  assign at_end = (cnt == div - ONE);
  // Looking one step ahead lets the registered tick line up with count div-1.
  assign tc     = (div == ONE) || (cnt == div - TWO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_end ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/slow_tick_ctrl.sv
// Run/stop controller for the slow tick divider: FSM, config handshake, tick, slow_clk, tick_count.
// Optional freeze input/state compiled in with SLOWTICK_PAUSE_EN; config accepted only while idle.
module slow_tick_ctrl
  import slow_tick_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [N-1:0]     cfg_div,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
`ifdef SLOWTICK_PAUSE_EN
  input  logic             pause,
`endif
  output logic             tick,
  output logic             slow_clk,
  output logic             busy,
  output logic [CNT_W-1:0] tick_count
);

  tick_state_t state, state_nx;
  logic [N-1:0] div_q, div_in, d_eff;
  logic         oneshot_q, os_eff;
  logic         pause_in;
  logic         cnt_clr, cnt_en, cnt_tc;
  logic         ev_tick, start_go;
  logic [N-1:0] cnt;

`ifdef SLOWTICK_PAUSE_EN
  assign pause_in = pause;
`else
  assign pause_in = 1'b0;
`endif

  assign div_in = N'(sanitize_div(64'(cfg_div)));
  // A config presented together with start is the one that run uses.
  assign d_eff  = cfg_valid ? div_in : div_q;
  assign os_eff = cfg_valid ? cfg_oneshot : oneshot_q;

  slow_tick_counter #(.N(N)) u_counter (
    .clk (clk),
    .rst (RESET),
    .clr (cnt_clr),
    .en  (cnt_en),
    .div (div_q),
    .cnt (cnt),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    ev_tick  = 1'b0;
    start_go = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          start_go = 1'b1;
          cnt_clr  = 1'b1;
          if (d_eff == N'(1)) begin
            ev_tick  = 1'b1;
            state_nx = os_eff ? IDLE : RUN;
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN, PAUSE: begin
        if (stop) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
        end else if (pause_in) begin
          state_nx = PAUSE;
        end else begin
          cnt_en   = 1'b1;
          state_nx = RUN;
          if (cnt_tc) begin
            ev_tick = 1'b1;
            if (oneshot_q) begin
              state_nx = IDLE;
              cnt_clr  = 1'b1;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      div_q      <= N'(1);
      oneshot_q  <= 1'b0;
      tick       <= 1'b0;
      slow_clk   <= 1'b0;
      tick_count <= '0;
    end else begin
      state <= state_nx;
      tick  <= ev_tick;
      if (state == IDLE && cfg_valid) begin
        div_q     <= div_in;
        oneshot_q <= cfg_oneshot;
      end
      if (start_go) begin
        tick_count <= ev_tick ? CNT_W'(1) : '0;
      end else if (ev_tick) begin
        tick_count <= tick_count + CNT_W'(1);
      end
      if (ev_tick) begin
        slow_clk <= ~slow_clk;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign cfg_ready = (state == IDLE);

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule
